// File: rtl/blinker_seq_pkg.sv
// Shared types, default sizes and the reset pattern helper for the blinker sequencer family.
package blinker_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_DIV_W      = 26;
    localparam int DEF_LED_W      = 8;
    localparam int DEF_STEPS      = 4;
    localparam int DEF_DIV_PERIOD = 50;
    localparam int RPT_W          = 8;
    localparam int MAX_PAT_W      = 1024;

    // Even steps all-ones, odd steps all-zeros; callers keep the low steps*led_w bits.
    function automatic logic [MAX_PAT_W-1:0] reset_pattern(input int steps, input int led_w);
        logic [MAX_PAT_W-1:0] ones;
        logic [MAX_PAT_W-1:0] p;
        ones = (MAX_PAT_W'(1) << led_w) - MAX_PAT_W'(1);
        p    = '0;
        for (int k = steps - 1; k >= 0; k--) begin
            p = p << led_w;
            if (k % 2 == 0) p = p | ones;
        end
        return p;
    endfunction

endpackage

// File: rtl/blinker_seq_ctrl_if.sv
// Configuration handshake bundle: the board logic offers a config, the sequencer accepts it.
interface blinker_seq_ctrl_if
    import blinker_seq_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int LED_W = DEF_LED_W,
    parameter int STEPS = DEF_STEPS
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [DIV_W-1:0]       cfg_period;
    logic [STEPS*LED_W-1:0] cfg_pattern;
    logic [RPT_W-1:0]       cfg_repeat;

    modport master (output cfg_valid, cfg_period, cfg_pattern, cfg_repeat, input cfg_ready);
    modport slave  (input cfg_valid, cfg_period, cfg_pattern, cfg_repeat, output cfg_ready);
endinterface

// File: rtl/blinker_seq_prescaler.sv
// Programmable wrap counter: counts 0..period_i-1 while enabled and pulses tick_o on the wrap cycle.
module blinker_seq_prescaler #(
    parameter int W = 26
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] period_i,
    output logic         tick_o
);
    logic [W-1:0] count_q, count_d;

    // period_i of 0 is never expected; it would wrap only after the full counter range.
    assign tick_o = en_i && !clear_i && (count_q == period_i - W'(1));

    always_comb begin
        count_d = count_q;
        if (clear_i)     count_d = '0;
        else if (tick_o) count_d = '0;
        else if (en_i)   count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/blinker_seq_ctrl.sv
// Step/repeat LED pattern sequencer with programmable step period.
// Optional PWM dimming of led_o is built when BLINKER_SEQ_DIM_EN is defined.
//   state | meaning
//   IDLE  | accepting config, waiting for start_i
//   RUN   | stepping through the pattern, busy_o high
//   DONE  | single cycle, done_o pulse after the last pass
module blinker_seq_ctrl
    import blinker_seq_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DIV_DEFAULT = DEF_DIV_PERIOD,
    parameter int LED_W       = DEF_LED_W,
    parameter int STEPS       = DEF_STEPS
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    blinker_seq_ctrl_if.slave cfg,
    input  logic              start_i,
    input  logic              stop_i,
`ifdef BLINKER_SEQ_DIM_EN
    input  logic [3:0]        dim_i,
`endif
    output logic [LED_W-1:0]  led_o,
    output logic              tick_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int PAT_W  = STEPS * LED_W;
    localparam int STEP_W = $clog2(STEPS);
    localparam logic [MAX_PAT_W-1:0] RST_PAT_FULL = reset_pattern(STEPS, LED_W);
    localparam logic [PAT_W-1:0]     RST_PAT      = RST_PAT_FULL[PAT_W-1:0];

    state_t             state_q, state_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [RPT_W-1:0]   pass_q, pass_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic               cfg_ready;
    logic               tick;
    logic [STEP_W-1:0]  step_nxt;
    logic [RPT_W-1:0]   pass_inc;

    blinker_seq_prescaler #(.W(DIV_W)) u_prescaler (
        .clk_sys  (system1000),
        .rst_b    (system1000_rstn),
        .clear_i  (state_q != RUN),
        .en_i     (state_q == RUN),
        .period_i (period_q),
        .tick_o   (tick)
    );

    assign step_nxt      = step_q + STEP_W'(1);
    assign pass_inc      = (pass_q == '1) ? pass_q : pass_q + RPT_W'(1);
    assign cfg.cfg_ready = cfg_ready;
    assign tick_o        = tick;
    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        step_d    = step_q;
        pass_d    = pass_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        rpt_d     = rpt_q;
        cfg_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    period_d  = (cfg.cfg_period == '0) ? DIV_W'(1) : cfg.cfg_period;
                    pattern_d = cfg.cfg_pattern;
                    rpt_d     = cfg.cfg_repeat;
                end
                if (start_i) begin
                    state_d = RUN;
                    step_d  = '0;
                    pass_d  = '0;
                    // A config offered alongside start_i already applies to this run.
                    led_d   = cfg.cfg_valid ? cfg.cfg_pattern[LED_W-1:0] : pattern_q[LED_W-1:0];
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (tick) begin
                    step_d = step_nxt;
                    led_d  = pattern_q[step_nxt*LED_W +: LED_W];
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        pass_d = pass_inc;
                        if (rpt_q != '0 && pass_inc == rpt_q) begin
                            state_d = DONE;
                            led_d   = '0;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                led_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q   <= IDLE;
            led_q     <= '0;
            step_q    <= '0;
            pass_q    <= '0;
            period_q  <= DIV_W'(DIV_DEFAULT);
            pattern_q <= RST_PAT;
            rpt_q     <= '0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            step_q    <= step_d;
            pass_q    <= pass_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            rpt_q     <= rpt_d;
        end
    end

`ifdef BLINKER_SEQ_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 4'd1;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) pwm_q <= '0;
        else                  pwm_q <= pwm_d;
    end

    assign led_o = led_q & {LED_W{pwm_q <= dim_i}};
`else
    assign led_o = led_q;
`endif
endmodule

// File: tb/tb_blinker_seq_ctrl.sv
// Directed self-checking bench for blinker_seq_ctrl (default sizes).
module tb_blinker_seq_ctrl;
    import blinker_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [7:0] led;
    logic       tick, busy, done;
`ifdef BLINKER_SEQ_DIM_EN
    logic [3:0] dim_i = 4'd15;
`endif

    int checks = 0;
    int errors = 0;

    blinker_seq_ctrl_if cfg_if ();

    blinker_seq_ctrl dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .cfg             (cfg_if.slave),
        .start_i         (start_i),
        .stop_i          (stop_i),
`ifdef BLINKER_SEQ_DIM_EN
        .dim_i           (dim_i),
`endif
        .led_o           (led),
        .tick_o          (tick),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [25:0] per, input logic [31:0] pat, input logic [7:0] rpt);
        cfg_if.cfg_period  = per;
        cfg_if.cfg_pattern = pat;
        cfg_if.cfg_repeat  = rpt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_defaults();
        logic [7:0] exp_led;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int c = 0; c < 120; c++) begin
            exp_led = ((c / 50) % 2 == 0) ? 8'hFF : 8'h00;
            checks++; if (led !== exp_led) begin errors++; $display("FAIL dflt_led c=%0d got=%h exp=%h", c, led, exp_led); end
            checks++; if (tick !== (c % 50 == 49)) begin errors++; $display("FAIL dflt_tick c=%0d got=%b", c, tick); end
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dflt_state c=%0d done=%b busy=%b exp done=0 busy=1", c, done, busy); end
            cyc();
        end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        checks++; if (busy !== 1'b0 || led !== 8'h00) begin errors++; $display("FAIL dflt_stop busy=%b led=%h exp 0/00", busy, led); end
    endtask

    task automatic test_normal_run();
        logic [7:0] exp_led;
        set_cfg(26'd3, {8'h08, 8'h04, 8'h02, 8'h01}, 8'd2);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 10) start_i = 1'b0;
            exp_led = 8'h01 << ((c / 3) % 4);
            checks++; if (led !== exp_led) begin errors++; $display("FAIL run_led c=%0d got=%h exp=%h", c, led, exp_led); end
            checks++; if (tick !== (c % 3 == 2)) begin errors++; $display("FAIL run_tick c=%0d got=%b", c, tick); end
            checks++; if (busy !== 1'b1 || done !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
                errors++; $display("FAIL run_state c=%0d busy=%b done=%b ready=%b exp 1/0/0", c, busy, done, cfg_if.cfg_ready);
            end
            cyc();
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || led !== 8'h00 || tick !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL run_done24 done=%b busy=%b led=%h tick=%b ready=%b exp 1/0/00/0/0", done, busy, led, tick, cfg_if.cfg_ready);
        end
        cyc();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL run_idle25 done=%b busy=%b ready=%b exp 0/0/1", done, busy, cfg_if.cfg_ready);
        end
    endtask

    task automatic test_stop();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        checks++; if (tick !== 1'b1 || led !== 8'h02) begin errors++; $display("FAIL stop_c5 tick=%b led=%h exp 1/02", tick, led); end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        checks++; if (busy !== 1'b0 || led !== 8'h00 || done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL stop_c6 busy=%b led=%h done=%b ready=%b exp 0/00/0/1", busy, led, done, cfg_if.cfg_ready);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (done !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL stop_after done=%b tick=%b exp 0/0", done, tick); end
        end
    endtask

    task automatic test_handshake();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        set_cfg(26'd1, 32'hAAAA_AAAA, 8'd0);
        cfg_if.cfg_valid = 1'b1;
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_run got=%b exp=0", cfg_if.cfg_ready); end
        for (int c = 0; c < 7; c++) begin
            checks++; if (led !== (8'h01 << (c / 3)) || tick !== (c % 3 == 2)) begin
                errors++; $display("FAIL hs_run c=%0d led=%h tick=%b", c, led, tick);
            end
            cyc();
        end
        cfg_if.cfg_valid = 1'b0;
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (led !== 8'h01 || tick !== (c == 2)) begin errors++; $display("FAIL hs_kept c=%0d led=%h tick=%b exp 01", c, led, tick); end
            cyc();
        end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        set_cfg(26'd1, {8'h44, 8'h33, 8'h22, 8'h11}, 8'd1);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (led !== 8'(8'h11 * (c + 1)) || tick !== 1'b1) begin
                errors++; $display("FAIL hs_same c=%0d led=%h tick=%b exp %h/1", c, led, tick, 8'(8'h11 * (c + 1)));
            end
            cyc();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hs_done got=%b exp=1", done); end
        cyc();
    endtask

    task automatic test_period_zero();
        set_cfg(26'd0, {8'h44, 8'h33, 8'h22, 8'h11}, 8'd1);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (led !== 8'(8'h11 * (c + 1)) || tick !== 1'b1) begin
                errors++; $display("FAIL p0 c=%0d led=%h tick=%b exp %h/1", c, led, tick, 8'(8'h11 * (c + 1)));
            end
            cyc();
        end
        checks++; if (done !== 1'b1 || led !== 8'h00) begin errors++; $display("FAIL p0_done done=%b led=%h exp 1/00", done, led); end
        cyc();
    endtask

    task automatic test_forever();
        set_cfg(26'd1, {8'h44, 8'h33, 8'h22, 8'h11}, 8'd0);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL forever c=%0d done=%b busy=%b exp 0/1", c, done, busy); end
            cyc();
        end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL forever_stop busy=%b exp 0", busy); end
    endtask

    task automatic test_async_reset();
        set_cfg(26'd3, {8'h08, 8'h04, 8'h02, 8'h01}, 8'd2);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (led !== 8'h00 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL arst led=%h busy=%b tick=%b done=%b exp 00/0/0/0", led, busy, tick, done);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL arst_pat got=%h exp=ff", led); end
        for (int c = 0; c < 49; c++) begin
            if (c == 48) begin
                checks++; if (tick !== 1'b0) begin errors++; $display("FAIL arst_tick48 got=%b exp=0", tick); end
            end
            cyc();
        end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL arst_tick49 got=%b exp=1", tick); end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
    endtask

`ifdef BLINKER_SEQ_DIM_EN
    task automatic test_dim();
        int on_cnt;
        on_cnt = 0;
        dim_i = 4'd3;
        set_cfg(26'd1000, 32'hFFFF_FFFF, 8'd0);
        cfg_if.cfg_valid = 1'b1;
        start_i = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 32; c++) begin
            checks++; if (led !== 8'hFF && led !== 8'h00) begin errors++; $display("FAIL dim_val c=%0d got=%h exp ff or 00", c, led); end
            if (led === 8'hFF) on_cnt++;
            cyc();
        end
        checks++; if (on_cnt != 8) begin errors++; $display("FAIL dim_duty on=%0d exp=8", on_cnt); end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        dim_i = 4'd15;
    endtask
`endif

    initial begin
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_period  = '0;
        cfg_if.cfg_pattern = '0;
        cfg_if.cfg_repeat  = '0;
        test_reset();
        test_defaults();
        test_normal_run();
        test_stop();
        test_handshake();
        test_period_zero();
        test_forever();
        test_async_reset();
`ifdef BLINKER_SEQ_DIM_EN
        test_dim();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blinker_seq_ctrl.md
Name: blinker_seq_ctrl

Overview:
Sequencer that drives the blinker LEDs through a programmable multi-step pattern. It owns a programmable tick prescaler (wrap counter) and a step/repeat FSM. Configuration arrives over a valid/ready handshake, and start/stop controls sequence it. Sits between the board control logic and the LED pins on the system1000 clock domain.

Parameters:
DIV_W, 26, prescaler/period width
DIV_DEFAULT, 50, period loaded at reset
LED_W, 8, LED output width
STEPS, 4, pattern steps (power of two, >=2)

Ports:
system1000  input  1  clock
system1000_rstn  input  1  reset; asynchronous, active-low
cfg_valid  input  1  config offer
cfg_ready  output  1  config accept; high only in IDLE
cfg_period  input  DIV_W  cycles per step
cfg_pattern  input  STEPS*LED_W  step k at bits [k*LED_W +: LED_W]
cfg_repeat  input  8  pattern passes; 0 = run forever
start_i  input  1  begin sequence (level sampled)
stop_i  input  1  abort sequence
led_o  output  LED_W  registered LED value
tick_o  output  1  one-cycle pulse at prescaler wrap
busy_o  output  1  high in RUN
done_o  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async assert, sync release):
  - state IDLE
  - led_o=0, tick_o=0, busy_o=0, done_o=0
  - period reg = DIV_DEFAULT, repeat reg = 0
  - pattern reg: even steps all-ones, odd steps all-zeros
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - cfg_valid&cfg_ready latches period/pattern/repeat.
  - cfg_period=0 is stored as 1.
  - start_i -> RUN next cycle.
  - If cfg_valid and start_i are high in the same cycle, the new config is used by that run.
- RUN entry cycle: prescaler=0, step=0, pass count=0, led_o=pattern[0], busy_o=1.
- Prescaler: counts 0..period-1. At period-1 it wraps to 0 and tick_o=1 that same cycle. Period 1 gives tick_o every cycle.
- On tick:
  - step increments, and led_o shows the new step on the following cycle.
  - When step wraps STEPS-1 -> 0, pass count increments (8-bit, saturating).
  - If repeat!=0 and pass count reaches repeat on this wrap: go to DONE, led_o=0.
- DONE: one cycle with done_o=1 and busy_o=0, then IDLE. cfg_ready=0 during DONE.
- stop_i in RUN: IDLE next cycle, led_o=0, busy_o=0, no done_o. stop_i has priority over a coincident tick or completion.
- start_i in RUN or DONE is ignored. stop_i in IDLE is ignored.
- cfg_valid outside IDLE: held off (cfg_ready=0); config regs unchanged.
- repeat=0: loops indefinitely until stop_i.
- Reset mid-run: immediate return to reset values; config regs revert to defaults.
- tick_o=0 outside RUN.

Optional Feature:
BLINKER_SEQ_DIM_EN:
- Defined:
  - Adds input dim_i[3:0] and a free-running 4-bit PWM counter (reset 0).
  - Each led_o bit = pattern bit AND (pwm_cnt <= dim_i).
  - dim_i=15 gives full on; dim_i=0 gives 1/16 duty.
  - Gating is applied on the registered output, so latency is unchanged.
- Undefined: no dim_i port, no PWM counter; led_o is the raw pattern.

Decomposition:
- Package blinker_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIV_W/LED_W/STEPS defaults, DIV_DEFAULT
  - repeat width constant (8)
  - reset pattern function
- Sub-module blinker_seq_prescaler:
  - programmable wrap counter with clear, enable and tick output
  - reusable by other blinker blocks

Test Plan:
- Reset defaults:
  - Stimulus: start_i with no config.
  - Response: led_o alternates 0xFF/0x00 every 50 cycles; tick_o every 50th cycle; never done.
- Normal run:
  - Stimulus: period=3, pattern {0x01,0x02,0x04,0x08}, repeat=2, start at cycle 0.
  - Response: led_o steps every 3 cycles; done_o at cycle 24; led_o=0; IDLE at 25.
- Stop:
  - Stimulus: stop_i coincident with a tick at cycle 5 of the above run.
  - Response: IDLE at cycle 6, led_o=0, no done_o, step not advanced.
- Handshake:
  - Stimulus: cfg_valid during RUN.
  - Response: cfg_ready=0 and config unchanged. Same-cycle cfg_valid+start_i in IDLE: new period=1 gives tick_o every cycle.
- Boundaries:
  - cfg_period=0 behaves as 1.
  - repeat=0 runs more than 1000 cycles with no done_o.
  - Async reset asserted mid-RUN: all outputs 0 immediately.
- BLINKER_SEQ_DIM_EN:
  - Stimulus: dim_i=3, pattern all 0xFF.
  - Response: led_o=0xFF for 4 of every 16 cycles.
